prio_dec_4to2_pend: RTL and testbench
=====================================

# prio_dec_4to2_pend

Registered 2-to-4 priority-code decoder with a pending-request register: the receiving end of the 4-to-2 priority encoder's {code, valid} output. It accepts encoded indices through a valid/ready handshake and re-expands each into a one-hot strobe through a single-entry output stage. It also accumulates every decoded index into a sticky pending vector that software or control logic clears write-1-to-clear, and flags a code that arrives while its bit is still pending.

## Interface
Parameters:
- CODE_W, default 2: code width; output/pending width is N = 2**CODE_W (4 by default).

Ports:
- clk  input  1  rising-edge clock; the single clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_code is valid this cycle.
- in_code  input  CODE_W  encoded index; 3 = highest priority.
- in_ready  output  1  block can accept a code this cycle.
- out_valid  output  1  out_onehot holds a decoded strobe.
- out_onehot  output  N  one-hot decode of the accepted code; all-zero when out_valid = 0.
- out_ready  input  1  downstream consumes out_onehot this cycle.
- pend_clr  input  N  write-1-to-clear mask for pend.
- pend  output  N  sticky pending bits, one per index.
- ovf  output  1  sticky overflow: a code arrived while its pend bit was set.
- ovf_clr  input  1  clears ovf.

## Operation
- in_ready = !rst && (!out_valid || out_ready): pass-through ready with a single output register and no skid buffer.
- Accept = in_valid && in_ready.
- On accept, at the next edge:
  - out_onehot <= 1 << in_code;
  - out_valid <= 1;
  - pend[in_code] <= 1.
- No accept while out_valid && out_ready: out_valid <= 0 and out_onehot <= 0 at the next edge.
- No accept and (out_valid && !out_ready): out_valid and out_onehot hold. They must not change while stalled.
- Pending update: pend_next = (pend & ~pend_clr) | set_mask, where set_mask = accept ? (1 << in_code) : 0.
  - If a bit is set and cleared in the same cycle, the set wins.
- ovf set condition: accept && pend[in_code] && !pend_clr[in_code], evaluated on the pre-edge pend.
- ovf_next = set_cond | (ovf & !ovf_clr); set wins over ovf_clr.
- in_code is always decoded as an unsigned value; the expected out_onehot is 1 << in_code. Illegal codes do not exist.
- out_onehot is always zero or exactly one-hot. A bench assertion checks this.

## Timing
- Reset (synchronous, rst = 1 at an edge) drives: out_valid = 0, out_onehot = 0, pend = 0, ovf = 0.
- in_ready = 0 while rst is high. It reads 1 the first cycle after rst deasserts.
- Latency: the code accepted at edge k appears on out_onehot/out_valid and in pend after edge k.
- Throughput: one code per cycle when out_ready is held at 1.
- Accept and drain in the same cycle: the new value replaces the old one with no bubble, and out_valid stays 1.
- Reset mid-transfer: a held strobe is discarded and pend/ovf are lost. Handshakes in the reset cycle have no effect.
- pend_clr and ovf_clr act at the next edge. They are level-sampled each cycle, not edge-detected.
- in_ready depends combinationally on out_ready and rst only. No other combinational input-to-output paths exist.

## Structure
- Shared package prio_pkg:
  - CODE_W default constant;
  - function onehot_decode(code) returning a 2**CODE_W-bit vector.
- One natural sub-module: prio_dec_2to4, a purely combinational code-to-one-hot decoder and the inverse of the encoder.
- Top-level contents: the output register, handshake, pend and ovf logic.
- Expected RTL size is about 150 lines including the sub-module.

## Test plan
- Reset then stream: hold out_ready = 1 and drive codes 0, 1, 2, 3 on consecutive cycles -> out_onehot = 0001, 0010, 0100, 1000 one cycle later each, out_valid continuous, pend = 1111, ovf = 0.
- Backpressure: accept code 2, then hold out_ready = 0 for 3 cycles with in_valid = 1 and in_code = 1 -> in_ready = 0, out_onehot stays 0100. Release -> 0010 follows with no bubble.
- Overflow: accept code 3 twice without clearing -> ovf = 1 after the second edge. Pulse ovf_clr -> ovf = 0. Then accept code 3 together with pend_clr = 1000 in the same cycle -> pend[3] = 1, ovf stays 0.
- Set-versus-clear race: with pend = 0100, drive pend_clr = 0110 while accepting code 1 -> pend = 0010.
- Mid-operation reset: with out_valid = 1, pend = 1010 and ovf = 1, assert rst for one cycle while in_valid = 1 -> all outputs 0, in_ready = 0 during reset, and the next code is accepted normally.
- Random constrained run: 10k cycles with random valid, ready and clear inputs -> scoreboard matches the reference model, and out_onehot is always zero or one-hot.

Source files
------------

// File: rtl/prio_pkg.sv
// Shared constants and helpers for the priority encode/decode pair.
// The default code width sets a 4-entry one-hot space.
package prio_pkg;

    localparam int CODE_W_DEF = 2;
    localparam int N_DEF      = 2 ** CODE_W_DEF;

    function automatic logic [N_DEF-1:0] onehot_decode(input logic [CODE_W_DEF-1:0] code);
        logic [N_DEF-1:0] res;
        res = '0;
        for (int unsigned i = 0; i < N_DEF; i++) begin
            if (code == CODE_W_DEF'(i)) begin
                res[i] = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/prio_dec_2to4.sv
// Purely combinational code-to-one-hot decoder, the inverse of the priority encoder.
// The output is always exactly one-hot for any input code.
module prio_dec_2to4
    import prio_pkg::*;
#(
    parameter int CODE_W = CODE_W_DEF
) (
    input  logic [CODE_W-1:0]      code,
    output logic [(2**CODE_W)-1:0] onehot
);

    localparam int N = 2 ** CODE_W;

    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (code == CODE_W'(i)) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prio_dec_4to2_pend.sv
// Registered code-to-one-hot decoder with a single-entry output stage,
// sticky write-1-to-clear pending bits and a sticky overflow flag.
module prio_dec_4to2_pend
    import prio_pkg::*;
#(
    parameter int CODE_W = CODE_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [CODE_W-1:0]       in_code,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [(2**CODE_W)-1:0]  out_onehot,
    input  logic                    out_ready,
    input  logic [(2**CODE_W)-1:0]  pend_clr,
    output logic [(2**CODE_W)-1:0]  pend,
    output logic                    ovf,
    input  logic                    ovf_clr
);

    localparam int N = 2 ** CODE_W;

    logic [N-1:0] dec;
    logic [N-1:0] set_mask;
    logic         accept;
    logic         ovf_set;

    prio_dec_2to4 #(
        .CODE_W(CODE_W)
    ) u_dec (
        .code   (in_code),
        .onehot (dec)
    );

    assign in_ready = !rst && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign set_mask = accept ? dec : '0;
    // Repeat arrival only counts if this cycle's clear is not already retiring the bit.
    assign ovf_set  = accept && |(dec & pend & ~pend_clr);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_onehot <= '0;
            pend       <= '0;
            ovf        <= 1'b0;
        end else begin
            if (accept) begin
                out_valid  <= 1'b1;
                out_onehot <= dec;
            end else if (out_ready) begin
                out_valid  <= 1'b0;
                out_onehot <= '0;
            end
            pend <= (pend & ~pend_clr) | set_mask;
            ovf  <= ovf_set | (ovf & !ovf_clr);
        end
    end

endmodule

// File: tb/tb_prio_dec_4to2_pend.sv
// Self-checking bench: directed vector table for the corner cases, then a
// randomized run against a bit-array reference model.
module tb_prio_dec_4to2_pend;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [1:0] in_code;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_onehot;
    logic       out_ready;
    logic [3:0] pend_clr;
    logic [3:0] pend;
    logic       ovf;
    logic       ovf_clr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    prio_dec_4to2_pend #(
        .CODE_W(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_code    (in_code),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_onehot (out_onehot),
        .out_ready  (out_ready),
        .pend_clr   (pend_clr),
        .pend       (pend),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr)
    );

    typedef struct {
        logic       rst;
        logic       iv;
        logic [1:0] code;
        logic       ordy;
        logic [3:0] pclr;
        logic       oclr;
        logic       e_rdy;
        logic       e_ov;
        logic [3:0] e_oh;
        logic [3:0] e_pend;
        logic       e_ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic iv, logic [1:0] c, logic ordy, logic [3:0] pclr,
                                logic oclr, logic e_rdy, logic e_ov, logic [3:0] e_oh,
                                logic [3:0] e_pend, logic e_ovf);
        vec_t v;
        v.rst = r; v.iv = iv; v.code = c; v.ordy = ordy; v.pclr = pclr; v.oclr = oclr;
        v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_oh = e_oh; v.e_pend = e_pend; v.e_ovf = e_ovf;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic iv, input logic [1:0] c, input logic ordy,
                         input logic [3:0] pclr, input logic oclr);
        rst = r; in_valid = iv; in_code = c; out_ready = ordy; pend_clr = pclr; ovf_clr = oclr;
    endtask

    task automatic post_checks(input int idx, input logic e_ov, input logic [3:0] e_oh,
                               input logic [3:0] e_pend, input logic e_ovf);
        chk("out_valid", idx, 32'(out_valid), 32'(e_ov));
        chk("out_onehot", idx, 32'(out_onehot), 32'(e_oh));
        chk("pend", idx, 32'(pend), 32'(e_pend));
        chk("ovf", idx, 32'(ovf), 32'(e_ovf));
        chk("onehot0", idx, 32'($onehot0(out_onehot)), 32'd1);
    endtask

    // Reference model state, kept as independent per-index flags.
    logic m_ov;
    int   m_code;
    logic m_pend[4];
    logic m_ovf;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(1'b1, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0);

        //           rst iv code ordy pclr    oclr rdy ov  oh       pend     ovf
        vecs.push_back(mk(1, 1, 2, 1, 4'b0000, 0,   0,  0, 4'b0000, 4'b0000, 0)); // reset
        vecs.push_back(mk(0, 1, 0, 1, 4'b0000, 0,   1,  1, 4'b0001, 4'b0001, 0)); // stream
        vecs.push_back(mk(0, 1, 1, 1, 4'b0000, 0,   1,  1, 4'b0010, 4'b0011, 0));
        vecs.push_back(mk(0, 1, 2, 1, 4'b0000, 0,   1,  1, 4'b0100, 4'b0111, 0));
        vecs.push_back(mk(0, 1, 3, 1, 4'b0000, 0,   1,  1, 4'b1000, 4'b1111, 0));
        vecs.push_back(mk(0, 0, 0, 1, 4'b1111, 0,   1,  0, 4'b0000, 4'b0000, 0)); // drain+clear
        vecs.push_back(mk(0, 1, 2, 1, 4'b0000, 0,   1,  1, 4'b0100, 4'b0100, 0)); // backpressure
        vecs.push_back(mk(0, 1, 1, 0, 4'b0000, 0,   0,  1, 4'b0100, 4'b0100, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'b0000, 0,   0,  1, 4'b0100, 4'b0100, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'b0000, 0,   0,  1, 4'b0100, 4'b0100, 0));
        vecs.push_back(mk(0, 1, 1, 1, 4'b0000, 0,   1,  1, 4'b0010, 4'b0110, 0)); // no bubble
        vecs.push_back(mk(0, 0, 0, 1, 4'b1111, 0,   1,  0, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(0, 1, 3, 1, 4'b0000, 0,   1,  1, 4'b1000, 4'b1000, 0)); // overflow
        vecs.push_back(mk(0, 1, 3, 1, 4'b0000, 0,   1,  1, 4'b1000, 4'b1000, 1));
        vecs.push_back(mk(0, 0, 0, 1, 4'b0000, 1,   1,  0, 4'b0000, 4'b1000, 0));
        vecs.push_back(mk(0, 1, 3, 1, 4'b1000, 0,   1,  1, 4'b1000, 4'b1000, 0)); // clr masks ovf
        vecs.push_back(mk(0, 1, 3, 1, 4'b0000, 0,   1,  1, 4'b1000, 4'b1000, 1));
        vecs.push_back(mk(0, 1, 3, 1, 4'b0000, 1,   1,  1, 4'b1000, 4'b1000, 1)); // set beats ovf_clr
        vecs.push_back(mk(0, 0, 0, 1, 4'b1111, 1,   1,  0, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(0, 1, 2, 1, 4'b0000, 0,   1,  1, 4'b0100, 4'b0100, 0)); // set/clear race
        vecs.push_back(mk(0, 1, 1, 1, 4'b0110, 0,   1,  1, 4'b0010, 4'b0010, 0));
        vecs.push_back(mk(0, 1, 3, 1, 4'b0000, 0,   1,  1, 4'b1000, 4'b1010, 0)); // mid reset
        vecs.push_back(mk(0, 1, 3, 1, 4'b0000, 0,   1,  1, 4'b1000, 4'b1010, 1));
        vecs.push_back(mk(1, 1, 0, 1, 4'b0000, 0,   0,  0, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(0, 1, 1, 1, 4'b0000, 0,   1,  1, 4'b0010, 4'b0010, 0));

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].iv, vecs[i].code, vecs[i].ordy, vecs[i].pclr, vecs[i].oclr);
            #1;
            chk("in_ready", i, 32'(in_ready), 32'(vecs[i].e_rdy));
            @(posedge clk);
            #1;
            post_checks(i, vecs[i].e_ov, vecs[i].e_oh, vecs[i].e_pend, vecs[i].e_ovf);
        end

        m_ov = 1'b0; m_code = 0; m_ovf = 1'b0;
        for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;

        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic       r, iv, ordy, oclr, e_rdy, acc;
            logic [1:0] c;
            logic [3:0] pclr, e_oh, e_pend;
            int         code;

            r    = (cyc == 0) || ($urandom_range(0, 199) == 0);
            iv   = $urandom_range(0, 3) != 0;
            c    = 2'($urandom_range(0, 3));
            ordy = $urandom_range(0, 3) != 0;
            pclr = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            oclr = $urandom_range(0, 7) == 0;
            code = int'(c);

            @(negedge clk);
            drive(r, iv, c, ordy, pclr, oclr);
            e_rdy = !r && (!m_ov || ordy);
            acc   = iv && e_rdy;
            #1;
            chk("rnd_in_ready", cyc, 32'(in_ready), 32'(e_rdy));

            if (r) begin
                m_ov = 1'b0; m_ovf = 1'b0;
                for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
            end else begin
                logic hit;
                hit   = acc && m_pend[code] && !pclr[code];
                m_ovf = hit || (m_ovf && !oclr);
                for (int i = 0; i < 4; i++) begin
                    m_pend[i] = (m_pend[i] && !pclr[i]) || (acc && code == i);
                end
                if (acc) begin
                    m_ov = 1'b1; m_code = code;
                end else if (ordy) begin
                    m_ov = 1'b0;
                end
            end

            e_oh   = m_ov ? 4'(1 << m_code) : 4'b0000;
            e_pend = '0;
            for (int i = 0; i < 4; i++) begin
                if (m_pend[i]) e_pend = e_pend + 4'(1 << i);
            end

            @(posedge clk);
            #1;
            post_checks(cyc, m_ov, e_oh, e_pend, m_ovf);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
